// File: rtl/pulse_train_gen_pkg.sv
// Shared definitions for the pulse train generator: FSM state encoding and
// default counter widths.
package pulse_train_gen_pkg;

  localparam int unsigned DEFAULT_WIDTH_BITS = 16;
  localparam int unsigned DEFAULT_COUNT_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_train_gen_phase_timer.sv
// Phase timer: loadable down-counter that flags the last cycle of an interval.
// A load of N gives N cycles; Expire is high in the N-th of them.
module phase_timer
  import pulse_train_gen_pkg::*;
#(
  parameter int unsigned WIDTH_BITS = DEFAULT_WIDTH_BITS
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Load,
  input  logic [WIDTH_BITS-1:0] LoadValue,
  output logic                  Expire
);

  localparam logic [WIDTH_BITS-1:0] W_ONE = WIDTH_BITS'(1);

  logic [WIDTH_BITS-1:0] r_count;

  // Reload on request, otherwise count down and hold at zero.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
    end else if (Load) begin
      r_count <= LoadValue;
    end else if (r_count != '0) begin
      r_count <= r_count - W_ONE;
    end
  end

  assign Expire = (r_count == W_ONE);

endmodule

// File: rtl/pulse_train_gen.sv
// Pulse train generator: emits PulseCount pulses of HighCycles high and
// LowCycles low (no trailing low gap), with Busy and a Done strobe.
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int unsigned WIDTH_BITS = DEFAULT_WIDTH_BITS,
  parameter int unsigned COUNT_BITS = DEFAULT_COUNT_BITS
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Abort,
  input  logic [WIDTH_BITS-1:0] HighCycles,
  input  logic [WIDTH_BITS-1:0] LowCycles,
  input  logic [COUNT_BITS-1:0] PulseCount,
  output logic                  Out,
  output logic                  Busy,
  output logic                  Done
);

  localparam logic [WIDTH_BITS-1:0] W_ONE = WIDTH_BITS'(1);
  localparam logic [COUNT_BITS-1:0] C_ONE = COUNT_BITS'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WIDTH_BITS-1:0] r_high_len;
  logic [WIDTH_BITS-1:0] r_low_len;
  logic [COUNT_BITS-1:0] r_pulses;
  logic [COUNT_BITS-1:0] w_pulses_nxt;
  logic                  w_latch;
  logic                  w_load;
  logic [WIDTH_BITS-1:0] w_load_val;
  logic                  w_done_nxt;
  logic                  w_expire;
  logic [WIDTH_BITS-1:0] w_high_in;
  logic [WIDTH_BITS-1:0] w_low_in;
  logic                  r_out;
  logic                  r_busy;
  logic                  r_done;

  // Zero-length phases are stretched to one cycle at latch time.
  assign w_high_in = (HighCycles == '0) ? W_ONE : HighCycles;
  assign w_low_in  = (LowCycles  == '0) ? W_ONE : LowCycles;

  phase_timer #(
    .WIDTH_BITS(WIDTH_BITS)
  ) u_phase_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .Load     (w_load),
    .LoadValue(w_load_val),
    .Expire   (w_expire)
  );

  // State, latched configuration, pulse counter and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_high_len <= '0;
      r_low_len  <= '0;
      r_pulses   <= '0;
      r_out      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pulses <= w_pulses_nxt;
      if (w_latch) begin
        r_high_len <= w_high_in;
        r_low_len  <= w_low_in;
      end
      // Outputs are the registered image of the next state, so they change
      // in the same cycle the state does.
      r_out  <= (w_state_nxt == ST_HIGH);
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= w_done_nxt;
    end
  end

  // Next-state, timer reload and completion decode; Abort overrides all.
  always_comb begin
    w_state_nxt  = r_state;
    w_pulses_nxt = r_pulses;
    w_latch      = 1'b0;
    w_load       = 1'b0;
    w_load_val   = r_high_len;
    w_done_nxt   = 1'b0;
    if (Abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (Start) begin
            w_latch      = 1'b1;
            w_pulses_nxt = PulseCount;
            if (PulseCount == '0) begin
              w_done_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_HIGH;
              w_load      = 1'b1;
              w_load_val  = w_high_in;
            end
          end
        end
        ST_HIGH: begin
          if (w_expire) begin
            if (r_pulses <= C_ONE) begin
              w_state_nxt  = ST_IDLE;
              w_pulses_nxt = '0;
              w_done_nxt   = 1'b1;
            end else begin
              w_state_nxt  = ST_LOW;
              w_pulses_nxt = r_pulses - C_ONE;
              w_load       = 1'b1;
              w_load_val   = r_low_len;
            end
          end
        end
        ST_LOW: begin
          if (w_expire) begin
            w_state_nxt = ST_HIGH;
            w_load      = 1'b1;
            w_load_val  = r_high_len;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign Out  = r_out;
  assign Busy = r_busy;
  assign Done = r_done;

endmodule

// File: doc/pulse_train_gen.md
PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 Parameter: WIDTH_BITS, default 16, width of the phase-length inputs and timer.
REQ-002 Parameter: COUNT_BITS, default 8, width of the pulse-count input and counter.
REQ-003 Clk  input  1  sole clock; all state updates on posedge Clk.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  single-cycle request to begin a pulse train.
REQ-006 Abort  input  1  terminate any train in progress.
REQ-007 HighCycles  input  WIDTH_BITS  cycles Out is high per pulse.
REQ-008 LowCycles  input  WIDTH_BITS  cycles Out is low between pulses.
REQ-009 PulseCount  input  COUNT_BITS  number of pulses in the train.
REQ-010 Out  output  1  registered pulse-train output.
REQ-011 Busy  output  1  high while a train is in progress.
REQ-012 Done  output  1  single-cycle strobe on normal train completion.

Function
REQ-013 The block SHALL implement states IDLE, HIGH and LOW, with IDLE as the only state that accepts Start.
REQ-014 In IDLE, Start=1 and Abort=0 at edge T SHALL latch HighCycles, LowCycles and PulseCount; later input changes SHALL NOT affect the running train.
REQ-015 If the latched PulseCount is non-zero, the block SHALL enter HIGH, with Out=1 and Busy=1 from cycle T+1.
REQ-016 A latched HighCycles or LowCycles value of 0 SHALL be treated as 1.
REQ-017 Out SHALL stay 1 for exactly max(HighCycles,1) cycles per pulse.
REQ-018 On exit from HIGH, if pulses remain, the block SHALL enter LOW; Out SHALL stay 0 for exactly max(LowCycles,1) cycles, then HIGH resumes.
REQ-019 After the final HIGH phase the block SHALL return to IDLE with no trailing LOW gap.
- Out=0, Busy=0 and Done=1 SHALL all occur in the first cycle after the final high cycle.
REQ-020 If the latched PulseCount is 0, the block SHALL stay in IDLE, keep Out=0 and Busy=0, and assert Done at T+1.
REQ-021 Done SHALL be high for exactly one cycle per completed train and SHALL NOT assert on abort.
REQ-022 Start while Busy=1 SHALL be ignored, with no effect on the running train.
REQ-023 Start in the same cycle Done asserts (Busy=0) SHALL be accepted, giving a back-to-back train with Out rising one cycle later.
REQ-024 Abort=1 at any edge SHALL force IDLE, with Out=0 and Busy=0 from the next cycle and Done=0.
REQ-025 Simultaneous Start and Abort SHALL resolve as Abort; Start is ignored.
REQ-026 Phase timer and pulse counter SHALL be unsigned down-counters sized WIDTH_BITS and COUNT_BITS.
- Neither counter SHALL wrap below zero.
- Maximum values (all-ones) SHALL produce exactly 2^N-1 cycles or pulses.
REQ-027 Out, Busy and Done SHALL be driven directly from flops, with no combinational path from any input.

Reset
REQ-028 While Reset=1, the block SHALL be in IDLE with Out=0, Busy=0, Done=0, and all counters and latched configuration cleared.
REQ-029 Reset asserted mid-train SHALL immediately clear Out and Busy (asynchronously), with no Done.
REQ-030 After Reset deasserts, the first Start SHALL be accepted on the first rising Clk edge.

Structure
REQ-031 A shared package SHALL hold the state encoding (IDLE, HIGH, LOW) and the default WIDTH_BITS and COUNT_BITS constants.
REQ-032 The phase timer SHALL be a separate sub-module, phase_timer.
- Ports: Clk, Reset, Load, LoadValue, Expire.
- Expire asserts in the last cycle of the loaded interval.
- It is instantiated once and reloaded at each phase change.

Verification
REQ-033 Start with High=3, Low=2, Count=3 -> Out pattern 1110011100111, then 0.
- Done pulses once, in the cycle after the 13th output cycle.
- Busy is high for exactly 13 cycles.
REQ-034 Start with High=0, Low=0, Count=2 -> Out pattern 101.
- Done follows immediately after the pattern.
REQ-035 Start with Count=0 -> Out and Busy stay 0; Done=1 at T+1 only.
REQ-036 Start with High=4, Low=4, Count=5; Abort in the 2nd LOW phase -> Out=0 and Busy=0 next cycle; Done never asserts.
- Same run: a Start pulse issued mid-train beforehand has no effect.
REQ-037 Start asserted in the Done cycle with High=1, Low=1, Count=1 -> new pulse on Out the following cycle.
REQ-038 Reset asserted during a HIGH phase -> Out=0 asynchronously; Done=0.
- A subsequent Start produces a full, correct train.
